// File: rtl/segment_scan_ctrl.sv
// rtl/segment_scan_ctrl.sv - scan scheduler for a 4-digit 7-segment time display
//
// Samples a {high[11:6], low[5:0]} time word once per scan frame, converts each
// field to BCD with a subtract-10 loop, and multiplexes the four digits over an
// 8-phase frame (odd phases blank).
//
// Ports:
//   clock       in   system clock
//   reset       in   asynchronous active-high reset
//   enable      in   scan run enable; low blanks the display and freezes the scan
//   data_show   in   12-bit time word
//   byte_status out  current scan phase 0..7
//   bytee       out  one-hot digit enable
//   segment     out  segment lines, bit0=a .. bit6=g
//   busy        out  BCD converter running
module segment_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [11:0] data_show,
    output logic [2:0]  byte_status,
    output logic [3:0]  bytee,
    output logic [6:0]  segment,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CONV_LO, CONV_HI, DONE} conv_state_e;

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    logic [15:0] div_q;
    logic [2:0]  phase_q;
    logic [3:0]  bytee_q, bytee_d;
    logic [6:0]  segment_q, segment_d;

    conv_state_e state_q, state_d;
    logic        load_q, load_d;
    logic [11:0] sample_q, sample_d;
    logic [5:0]  rem_q, rem_d;
    logic [3:0]  tens_q, tens_d;

    // {tens, ones} per field; oor bit0 = low field, bit1 = high field
    logic [7:0]  pend_lo_q, pend_lo_d, pend_hi_q, pend_hi_d;
    logic [1:0]  pend_oor_q, pend_oor_d;
    logic [7:0]  com_lo_q, com_hi_q;
    logic [1:0]  com_oor_q;

    logic        tick, frame;
    logic [3:0]  digit;
    logic        dash;

    assign tick  = (div_q == DIV_LAST) && enable;
    assign frame = tick && (phase_q == 3'd7);

    assign byte_status = phase_q;
    assign bytee       = bytee_q;
    assign segment     = segment_q;
    assign busy        = (state_q != IDLE);

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    seg_encode = 7'h3F;
            4'd1:    seg_encode = 7'h06;
            4'd2:    seg_encode = 7'h5B;
            4'd3:    seg_encode = 7'h4F;
            4'd4:    seg_encode = 7'h66;
            4'd5:    seg_encode = 7'h6D;
            4'd6:    seg_encode = 7'h7D;
            4'd7:    seg_encode = 7'h07;
            4'd8:    seg_encode = 7'h7F;
            4'd9:    seg_encode = 7'h6F;
            default: seg_encode = 7'h00;
        endcase
    endfunction

    // Divider and phase freeze while enable is low so the scan resumes in place.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            phase_q <= '0;
        end else if (enable) begin
            if (div_q == DIV_LAST) begin
                div_q   <= '0;
                phase_q <= phase_q + 3'd1;
            end else begin
                div_q <= div_q + 16'd1;
            end
        end
    end

    always_comb begin
        bytee_d   = 4'b0000;
        segment_d = 7'h00;
        digit     = 4'd0;
        dash      = 1'b0;
        if (enable) begin
            case (phase_q)
                3'd0: begin bytee_d = 4'b0001; digit = com_lo_q[3:0]; dash = com_oor_q[0]; end
                3'd2: begin bytee_d = 4'b0010; digit = com_lo_q[7:4]; dash = com_oor_q[0]; end
                3'd4: begin bytee_d = 4'b0100; digit = com_hi_q[3:0]; dash = com_oor_q[1]; end
                3'd6: begin bytee_d = 4'b1000; digit = com_hi_q[7:4]; dash = com_oor_q[1]; end
                default: ;
            endcase
            if (bytee_d != 4'b0000) begin
                segment_d = dash ? 7'h40 : seg_encode(digit);
            end
        end
    end

    // Converter: the first CONV_LO cycle loads the low field; each field store
    // also loads the next field so CONV_HI starts evaluating immediately.
    always_comb begin
        state_d    = state_q;
        load_d     = 1'b0;
        sample_d   = sample_q;
        rem_d      = rem_q;
        tens_d     = tens_q;
        pend_lo_d  = pend_lo_q;
        pend_hi_d  = pend_hi_q;
        pend_oor_d = pend_oor_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (frame) begin
                    state_d  = CONV_LO;
                    sample_d = data_show;
                    load_d   = 1'b1;
                end
            end
            CONV_LO: begin
                if (load_q) begin
                    rem_d  = sample_q[5:0];
                    tens_d = 4'd0;
                end else if (rem_q > 6'd59) begin
                    pend_lo_d     = 8'h00;
                    pend_oor_d[0] = 1'b1;
                    rem_d         = sample_q[11:6];
                    tens_d        = 4'd0;
                    state_d       = CONV_HI;
                end else if (rem_q >= 6'd10) begin
                    rem_d  = rem_q - 6'd10;
                    tens_d = tens_q + 4'd1;
                end else begin
                    pend_lo_d     = {tens_q, rem_q[3:0]};
                    pend_oor_d[0] = 1'b0;
                    rem_d         = sample_q[11:6];
                    tens_d        = 4'd0;
                    state_d       = CONV_HI;
                end
            end
            CONV_HI: begin
                if (rem_q > 6'd59) begin
                    pend_hi_d     = 8'h00;
                    pend_oor_d[1] = 1'b1;
                    state_d       = DONE;
                end else if (rem_q >= 6'd10) begin
                    rem_d  = rem_q - 6'd10;
                    tens_d = tens_q + 4'd1;
                end else begin
                    pend_hi_d     = {tens_q, rem_q[3:0]};
                    pend_oor_d[1] = 1'b0;
                    state_d       = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Commit reads the pending registers before this edge's converter write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bytee_q    <= '0;
            segment_q  <= '0;
            state_q    <= IDLE;
            load_q     <= 1'b0;
            sample_q   <= '0;
            rem_q      <= '0;
            tens_q     <= '0;
            pend_lo_q  <= '0;
            pend_hi_q  <= '0;
            pend_oor_q <= '0;
            com_lo_q   <= '0;
            com_hi_q   <= '0;
            com_oor_q  <= '0;
        end else begin
            bytee_q    <= bytee_d;
            segment_q  <= segment_d;
            state_q    <= state_d;
            load_q     <= load_d;
            sample_q   <= sample_d;
            rem_q      <= rem_d;
            tens_q     <= tens_d;
            pend_lo_q  <= pend_lo_d;
            pend_hi_q  <= pend_hi_d;
            pend_oor_q <= pend_oor_d;
            if (frame) begin
                com_lo_q  <= pend_lo_q;
                com_hi_q  <= pend_hi_q;
                com_oor_q <= pend_oor_q;
            end
        end
    end

endmodule

// File: tb/tb_segment_scan_ctrl.sv
// tb/tb_segment_scan_ctrl.sv - self-checking bench for segment_scan_ctrl
module tb_segment_scan_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [11:0] data_show = 12'd0;
    logic [2:0]  byte_status;
    logic [3:0]  bytee;
    logic [6:0]  segment;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [3:0] b;
        logic [6:0] s;
    } exp_t;

    exp_t exp_q[$];

    segment_scan_ctrl #(.SCAN_DIV(4)) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .data_show(data_show),
        .byte_status(byte_status),
        .bytee(bytee),
        .segment(segment),
        .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Waits for a later negedge where byte_status equals p; timeout counts as a miss.
    task automatic wait_phase(input logic [2:0] p);
        int n = 0;
        @(negedge clock);
        while (byte_status !== p && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (byte_status !== p) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_phase: byte_status=%0d required %0d", byte_status, p);
        end
    endtask

    task automatic wait_boundary();
        wait_phase(3'd7);
        wait_phase(3'd0);
    endtask

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s2,
                              input logic [6:0] s4, input logic [6:0] s6);
        exp_q.push_back(exp_t'({4'b0001, s0}));
        exp_q.push_back(exp_t'({4'b0000, 7'h00}));
        exp_q.push_back(exp_t'({4'b0010, s2}));
        exp_q.push_back(exp_t'({4'b0000, 7'h00}));
        exp_q.push_back(exp_t'({4'b0100, s4}));
        exp_q.push_back(exp_t'({4'b0000, 7'h00}));
        exp_q.push_back(exp_t'({4'b1000, s6}));
        exp_q.push_back(exp_t'({4'b0000, 7'h00}));
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if (byte_status !== 3'd0) begin miscompares++; $display("FAIL reset byte_status: got %0d required 0", byte_status); end
        vectors++;
        if (bytee !== 4'b0000) begin miscompares++; $display("FAIL reset bytee: got %b required 0000", bytee); end
        vectors++;
        if (segment !== 7'h00) begin miscompares++; $display("FAIL reset segment: got %h required 00", segment); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b required 0", busy); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        enable = 1'b1;
        for (int e = 0; e < 40; e++) begin
            @(negedge clock);
            vectors++;
            if (byte_status !== 3'((e / 4) % 8)) begin
                miscompares++;
                $display("FAIL scan step %0d: byte_status=%0d required %0d", e, byte_status, (e / 4) % 8);
            end
        end
    endtask

    task automatic test_digits();
        data_show = {6'd23, 6'd45};
        push_frame(7'h6D, 7'h66, 7'h4F, 7'h5B);
        wait_boundary();
        wait_boundary();
        for (int p = 0; p < 8; p++) begin
            exp_t e;
            wait_phase(3'(p));
            @(negedge clock);
            e = exp_q.pop_front();
            vectors++;
            if (bytee !== e.b || segment !== e.s) begin
                miscompares++;
                $display("FAIL digits phase %0d: bytee=%b segment=%h required bytee=%b segment=%h", p, bytee, segment, e.b, e.s);
            end
        end
    endtask

    task automatic test_out_of_range();
        data_show = {6'd63, 6'd07};
        push_frame(7'h07, 7'h3F, 7'h40, 7'h40);
        wait_boundary();
        wait_boundary();
        for (int p = 0; p < 8; p++) begin
            exp_t e;
            wait_phase(3'(p));
            @(negedge clock);
            e = exp_q.pop_front();
            vectors++;
            if (bytee !== e.b || segment !== e.s) begin
                miscompares++;
                $display("FAIL out_of_range phase %0d: bytee=%b segment=%h required bytee=%b segment=%h", p, bytee, segment, e.b, e.s);
            end
        end
    endtask

    task automatic test_mid_frame();
        data_show = {6'd12, 6'd34};
        exp_q.push_back(exp_t'({4'b0001, 7'h66}));
        wait_boundary();
        wait_boundary();
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            if (k > 0) wait_boundary();
            wait_phase(3'd0);
            @(negedge clock);
            e = exp_q.pop_front();
            vectors++;
            if (bytee !== e.b || segment !== e.s) begin
                miscompares++;
                $display("FAIL mid_frame frame %0d: bytee=%b segment=%h required bytee=%b segment=%h", k, bytee, segment, e.b, e.s);
            end
            if (k == 0) begin
                wait_phase(3'd3);
                data_show = {6'd12, 6'd35};
                exp_q.push_back(exp_t'({4'b0001, 7'h66}));
                exp_q.push_back(exp_t'({4'b0001, 7'h6D}));
            end
        end
    endtask

    task automatic test_enable();
        exp_t e;
        wait_phase(3'd2);
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            vectors++;
            if (bytee !== 4'b0000 || segment !== 7'h00 || byte_status !== 3'd2) begin
                miscompares++;
                $display("FAIL enable_low cycle %0d: bytee=%b segment=%h byte_status=%0d required 0000 00 2", k, bytee, segment, byte_status);
            end
        end
        enable = 1'b1;
        exp_q.push_back(exp_t'({4'b0010, 7'h4F}));
        @(negedge clock);
        e = exp_q.pop_front();
        vectors++;
        if (bytee !== e.b || segment !== e.s) begin
            miscompares++;
            $display("FAIL enable_resume: bytee=%b segment=%h required bytee=%b segment=%h", bytee, segment, e.b, e.s);
        end
        @(negedge clock);
        @(negedge clock);
        vectors++;
        if (byte_status !== 3'd2) begin miscompares++; $display("FAIL enable_hold_count: byte_status=%0d required 2", byte_status); end
        @(negedge clock);
        vectors++;
        if (byte_status !== 3'd3) begin miscompares++; $display("FAIL enable_advance: byte_status=%0d required 3", byte_status); end
    endtask

    task automatic test_busy();
        int n = 0;
        data_show = {6'd59, 6'd59};
        push_frame(7'h6F, 7'h6D, 7'h6F, 7'h6D);
        wait_phase(3'd7);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_idle: busy=%b required 0", busy); end
        wait_phase(3'd0);
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clock);
        end
        vectors++;
        if (n != 14) begin miscompares++; $display("FAIL busy_length: busy cycles=%0d required 14", n); end
        wait_boundary();
        for (int p = 0; p < 8; p++) begin
            exp_t e;
            wait_phase(3'(p));
            @(negedge clock);
            e = exp_q.pop_front();
            vectors++;
            if (bytee !== e.b || segment !== e.s) begin
                miscompares++;
                $display("FAIL busy_display phase %0d: bytee=%b segment=%h required bytee=%b segment=%h", p, bytee, segment, e.b, e.s);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        wait_phase(3'd2);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (byte_status !== 3'd0 || bytee !== 4'b0000 || segment !== 7'h00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: byte_status=%0d bytee=%b segment=%h busy=%b required 0 0000 00 0", byte_status, bytee, segment, busy);
        end
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.push_back(exp_t'({4'b0001, 7'h3F}));
        @(negedge clock);
        @(negedge clock);
        e = exp_q.pop_front();
        vectors++;
        if (bytee !== e.b || segment !== e.s || byte_status !== 3'd0) begin
            miscompares++;
            $display("FAIL post_reset_digits: bytee=%b segment=%h byte_status=%0d required bytee=%b segment=%h byte_status=0", bytee, segment, byte_status, e.b, e.s);
        end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_out_of_range();
        test_mid_frame();
        test_enable();
        test_busy();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
